// File: rtl/pc_pkg.sv
// Shared op codes and FSM state encoding for the program-counter sequencer.
package pc_pkg;
  localparam logic [3:0] PC_HOLD    = 4'd0;
  localparam logic [3:0] PC_INC     = 4'd1;
  localparam logic [3:0] PC_BR_ABS  = 4'd2;
  localparam logic [3:0] PC_JUMP    = 4'd3;
  localparam logic [3:0] PC_HALT    = 4'd4;
  localparam logic [3:0] PC_WAIT_IN = 4'd5;
  localparam logic [3:0] PC_BR_REL  = 4'd6;
  localparam logic [3:0] PC_CALL    = 4'd7;
  localparam logic [3:0] PC_RET     = 4'd8;

  typedef enum logic {ST_RUN, ST_HALTED} state_e;
endpackage

// File: rtl/return_stack.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest entry.
module return_stack #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign overflow = push & full;
  assign pop_data = mem[wp_q - 1'b1];

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push) begin
      wp_d = wp_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      wp_d  = wp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset: the count alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (reset && push) mem[wp_q] <= push_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC mux, RUN/HALTED FSM, return stack and sticky error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter int                 IMM_W      = 11,
  parameter int                 RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        pc_op,
  input  logic              cond,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [ADDR_W-1:0] jump,
  input  logic              processIn,
  input  logic              stall,
  output logic [ADDR_W-1:0] outPC,
  output logic              halted,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic              illegal_op
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              ovf_q, ovf_d, udf_q, udf_d, ill_q, ill_d;
  logic              push, pop;
  logic [ADDR_W-1:0] pop_data;
  logic              ras_full, ras_empty, ras_ovf;

  return_stack #(.DEPTH(RAS_DEPTH), .ADDR_W(ADDR_W)) u_ras (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .push_data(pc_inc), .pop_data(pop_data),
    .full(ras_full), .empty(ras_empty), .overflow(ras_ovf)
  );

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    ill_d   = ill_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (!stall && state_q == ST_RUN) begin
      case (pc_op)
        PC_HOLD:    ;
        PC_INC:     pc_d = pc_inc;
        PC_BR_ABS:  pc_d = cond ? ADDR_W'(immediate) : pc_inc;
        PC_JUMP:    pc_d = jump;
        PC_HALT:    state_d = ST_HALTED;
        PC_WAIT_IN: pc_d = pc_q + ADDR_W'(processIn);
        PC_BR_REL:  pc_d = cond ? pc_q + {{(ADDR_W-IMM_W){immediate[IMM_W-1]}}, immediate}
                                : pc_inc;
        PC_CALL: begin
          push  = 1'b1;
          pc_d  = jump;
          ovf_d = ovf_q | ras_ovf;
        end
        PC_RET: begin
          if (ras_empty) begin
            pc_d  = pc_inc;
            udf_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = pop_data;
          end
        end
        default:    ill_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_ADDR;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      ill_q   <= ill_d;
    end
  end

  assign outPC         = pc_q;
  assign halted        = (state_q == ST_HALTED);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = udf_q;
  assign illegal_op    = ill_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer with a queue-based reference model and a randomized run.
module tb_pc_sequencer;
  localparam int          ADDR_W = 32;
  localparam int          IMM_W  = 11;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] RA     = 32'h10;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [3:0]        pc_op = 4'd0;
  logic              cond = 1'b0;
  logic [IMM_W-1:0]  immediate = '0;
  logic [ADDR_W-1:0] jump = '0;
  logic              processIn = 1'b0;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] outPC;
  logic              halted, ras_overflow, ras_underflow, illegal_op;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_halt, m_ovf, m_udf, m_ill;
  logic [31:0] m_ras[$];

  pc_sequencer #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .RAS_DEPTH(DEPTH), .RESET_ADDR(RA)) dut (
    .clock(clock), .reset(reset), .pc_op(pc_op), .cond(cond), .immediate(immediate),
    .jump(jump), .processIn(processIn), .stall(stall), .outPC(outPC), .halted(halted),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    int off;
    if (!reset) begin
      m_pc = RA; m_halt = 0; m_ovf = 0; m_udf = 0; m_ill = 0;
      m_ras.delete();
    end else if (!stall && !m_halt) begin
      case (pc_op)
        4'd0: ;
        4'd1: m_pc = m_pc + 1;
        4'd2: m_pc = cond ? {21'd0, immediate} : m_pc + 1;
        4'd3: m_pc = jump;
        4'd4: m_halt = 1;
        4'd5: m_pc = m_pc + (processIn ? 1 : 0);
        4'd6: begin off = $signed(immediate); m_pc = cond ? m_pc + off : m_pc + 1; end
        4'd7: begin
          m_ras.push_back(m_pc + 1);
          if (m_ras.size() > DEPTH) begin m_ras.pop_front(); m_ovf = 1; end
          m_pc = jump;
        end
        4'd8: begin
          if (m_ras.size() == 0) begin m_pc = m_pc + 1; m_udf = 1; end
          else m_pc = m_ras.pop_back();
        end
        default: m_ill = 1;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic [3:0] o, input logic c = 0, input logic [IMM_W-1:0] imm = '0,
                    input logic [31:0] j = '0);
    pc_op = o; cond = c; immediate = imm; jump = j;
    tick();
  endtask

  task automatic do_reset();
    reset = 0; pc_op = 0; stall = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0; stall = 1; pc_op = 4'd3; jump = 32'hDEAD;
    tick();
    checks++;
    if (outPC !== RA || {halted, ras_overflow, ras_underflow, illegal_op} !== 4'b0) begin
      failures++;
      $display("FAIL reset pc=%h flags=%b exp pc=%h flags=0000", outPC,
               {halted, ras_overflow, ras_underflow, illegal_op}, RA);
    end
    reset = 1; stall = 0;
    for (int i = 1; i <= 3; i++) begin
      op(4'd1);
      checks++;
      if (outPC !== RA + i) begin
        failures++; $display("FAIL inc%0d pc=%h exp=%h", i, outPC, RA + i);
      end
    end
  endtask

  task automatic test_branch();
    op(4'd3, 0, '0, 32'h20);
    op(4'd6, 1, 11'h7FE);
    checks++;
    if (outPC !== 32'h1E) begin failures++; $display("FAIL br_rel_taken pc=%h exp=1e", outPC); end
    op(4'd3, 0, '0, 32'h20);
    op(4'd6, 0, 11'h7FE);
    checks++;
    if (outPC !== 32'h21) begin failures++; $display("FAIL br_rel_nt pc=%h exp=21", outPC); end
    op(4'd2, 1, 11'h055);
    checks++;
    if (outPC !== 32'h55) begin failures++; $display("FAIL br_abs pc=%h exp=55", outPC); end
    op(4'd2, 0, 11'h3FF);
    checks++;
    if (outPC !== 32'h56) begin failures++; $display("FAIL br_abs_nt pc=%h exp=56", outPC); end
  endtask

  task automatic test_call_ret();
    op(4'd3, 0, '0, 32'h40);
    op(4'd7, 0, '0, 32'h100);
    checks++;
    if (outPC !== 32'h100) begin failures++; $display("FAIL call pc=%h exp=100", outPC); end
    op(4'd8);
    checks++;
    if (outPC !== 32'h41) begin failures++; $display("FAIL ret pc=%h exp=41", outPC); end
    checks++;
    if (ras_underflow !== 1'b0) begin failures++; $display("FAIL udf_early got=%b exp=0", ras_underflow); end
    op(4'd8);
    checks++;
    if (outPC !== 32'h42 || ras_underflow !== 1'b1) begin
      failures++; $display("FAIL ret_empty pc=%h udf=%b exp pc=42 udf=1", outPC, ras_underflow);
    end
  endtask

  task automatic test_ras_overflow();
    do_reset();
    op(4'd3, 0, '0, 32'h0);
    for (int k = 0; k <= DEPTH; k++) begin
      op(4'd7, 0, '0, 32'(k + 1));
      if (k == DEPTH - 1) begin
        checks++;
        if (ras_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", ras_overflow); end
      end
    end
    checks++;
    if (ras_overflow !== 1'b1) begin failures++; $display("FAIL ovf got=%b exp=1", ras_overflow); end
    for (int r = 0; r < DEPTH; r++) begin
      op(4'd8);
      checks++;
      if (outPC !== 32'(DEPTH + 1 - r) || ras_underflow !== 1'b0) begin
        failures++;
        $display("FAIL ovf_ret%0d pc=%h udf=%b exp pc=%h udf=0", r, outPC, ras_underflow, DEPTH + 1 - r);
      end
    end
    op(4'd8);
    checks++;
    if (outPC !== 32'h3 || ras_underflow !== 1'b1) begin
      failures++; $display("FAIL ovf_lost pc=%h udf=%b exp pc=3 udf=1", outPC, ras_underflow);
    end
  endtask

  task automatic test_wait_stall();
    op(4'd3, 0, '0, 32'h80);
    processIn = 0;
    for (int i = 0; i < 3; i++) begin
      op(4'd5);
      checks++;
      if (outPC !== 32'h80) begin failures++; $display("FAIL wait_hold%0d pc=%h exp=80", i, outPC); end
    end
    processIn = 1;
    op(4'd5);
    checks++;
    if (outPC !== 32'h81) begin failures++; $display("FAIL wait_go pc=%h exp=81", outPC); end
    processIn = 0;
    stall = 1;
    op(4'd3, 0, '0, 32'h999);
    op(4'd7, 0, '0, 32'h777);
    checks++;
    if (outPC !== 32'h81) begin failures++; $display("FAIL stall pc=%h exp=81", outPC); end
    stall = 0;
    op(4'd8);
    checks++;
    if (outPC !== 32'h82 || ras_underflow !== 1'b1) begin
      failures++; $display("FAIL stall_ras pc=%h udf=%b exp pc=82 udf=1", outPC, ras_underflow);
    end
  endtask

  task automatic test_halt_illegal_wrap();
    op(4'd4);
    checks++;
    if (halted !== 1'b1 || outPC !== 32'h82) begin
      failures++; $display("FAIL halt halted=%b pc=%h exp 1/82", halted, outPC);
    end
    for (int i = 0; i < 4; i++) begin
      op(i[0] ? 4'd1 : 4'd3, 0, '0, 32'h500);
      checks++;
      if (halted !== 1'b1 || outPC !== 32'h82) begin
        failures++; $display("FAIL halt_hold%0d halted=%b pc=%h exp 1/82", i, halted, outPC);
      end
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || outPC !== RA) begin
      failures++; $display("FAIL halt_reset halted=%b pc=%h exp 0/%h", halted, outPC, RA);
    end
    op(4'd12);
    checks++;
    if (illegal_op !== 1'b1 || outPC !== RA) begin
      failures++; $display("FAIL illegal ill=%b pc=%h exp 1/%h", illegal_op, outPC, RA);
    end
    op(4'd3, 0, '0, 32'hFFFF_FFFF);
    op(4'd1);
    checks++;
    if (outPC !== 32'h0 || illegal_op !== 1'b1) begin
      failures++; $display("FAIL wrap pc=%h ill=%b exp 0/1", outPC, illegal_op);
    end
  endtask

  task automatic test_random();
    logic [3:0] o;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      o = 4'($urandom_range(0, 15));
      if (o == 4'd4 && $urandom_range(0, 7) != 0) o = 4'd7;
      reset     = ($urandom_range(0, 59) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      processIn = 1'($urandom_range(0, 1));
      op(o, 1'($urandom_range(0, 1)), IMM_W'($urandom), ($urandom_range(0, 1) != 0) ?
         32'($urandom_range(0, 255)) : $urandom);
      checks++;
      if (outPC !== m_pc || halted !== m_halt || ras_overflow !== m_ovf ||
          ras_underflow !== m_udf || illegal_op !== m_ill) begin
        failures++;
        $display("FAIL rand%0d pc=%h h=%b o=%b u=%b i=%b exp pc=%h h=%b o=%b u=%b i=%b", n,
                 outPC, halted, ras_overflow, ras_underflow, illegal_op,
                 m_pc, m_halt, m_ovf, m_udf, m_ill);
      end
    end
    reset = 1; stall = 0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_wait_stall();
    test_halt_illegal_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
